// File: rtl/ext_trig_cond.sv
// ext_trig_cond: external trigger pin conditioner.
// Synchronises the raw pin, picks the qualifying edge, applies a hold-off
// window, and produces a one-cycle trigger, a stretched copy, and
// saturating accept/drop counters.
module ext_trig_cond #(
  parameter int ACT_LVL = 0,
  parameter int DEB_W   = 20,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic             adc_clk_i,
  input  logic             adc_rstn_i,
  input  logic             trig_ext_i,
  input  logic             cfg_edge_i,
  input  logic [DEB_W-1:0] cfg_deb_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             cnt_clr_i,
  output logic             lvl_o,
  output logic             trig_o,
  output logic             trig_stretch_o,
  output logic [CNT_W-1:0] trig_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  // Synchroniser resets to the pin's idle level so reset release is edge-free.
  localparam logic       PIN_IDLE = (ACT_LVL != 0) ? 1'b0 : 1'b1;

  logic             s1_q, s2_q, s3_q;
  logic             n_cur, n_prev, qual, accept, drop;
  logic [0:0]       state_q, state_d;
  logic [DEB_W-1:0] hold_q, hold_d;
  logic [LEN_W-1:0] str_q, str_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d, dcnt_q, dcnt_d;
  logic             trig_q, lvl_q;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      s1_q <= PIN_IDLE;
      s2_q <= PIN_IDLE;
      s3_q <= PIN_IDLE;
    end else begin
      s1_q <= trig_ext_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Normalise to active-high and qualify the selected edge.
  always_comb begin
    n_cur  = (ACT_LVL != 0) ? s2_q : ~s2_q;
    n_prev = (ACT_LVL != 0) ? s3_q : ~s3_q;
    qual   = cfg_edge_i ? (n_prev & ~n_cur) : (~n_prev & n_cur);
    accept = qual && (state_q == ST_IDLE);
    drop   = qual && (state_q == ST_HOLD);
  end

  // Hold-off FSM: the counter runs D..1 in HOLD, so the next acceptance
  // can occur no sooner than D+1 cycles after the previous one.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (qual) begin
          hold_d = cfg_deb_i;
          if (cfg_deb_i != '0) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q <= DEB_W'(1)) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - DEB_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Stretch counter reloads on every acceptance, so retriggers extend it.
  always_comb begin
    str_d = str_q;
    if (accept)           str_d = cfg_len_i;
    else if (str_q != '0) str_d = str_q - LEN_W'(1);
  end

  // Saturating counters; clear beats a same-cycle increment.
  always_comb begin
    tcnt_d = tcnt_q;
    dcnt_d = dcnt_q;
    if (cnt_clr_i) begin
      tcnt_d = '0;
      dcnt_d = '0;
    end else begin
      if (accept && (tcnt_q != {CNT_W{1'b1}})) tcnt_d = tcnt_q + CNT_W'(1);
      if (drop   && (dcnt_q != {CNT_W{1'b1}})) dcnt_d = dcnt_q + CNT_W'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      str_q   <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      trig_q  <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      str_q   <= str_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
      trig_q  <= accept;
      lvl_q   <= n_cur;
    end
  end

  assign lvl_o          = lvl_q;
  assign trig_o         = trig_q;
  assign trig_stretch_o = (str_q != '0);
  assign trig_cnt_o     = tcnt_q;
  assign drop_cnt_o     = dcnt_q;

endmodule

// File: tb/tb_ext_trig_cond.sv
// Bench for ext_trig_cond (active-low pin, 4-bit counters).
// Reference model works on pin history and acceptance times: an edge is
// accepted when it is at least D+1 cycles after the last acceptance.
module tb_ext_trig_cond;
  localparam int ACT   = 0;
  localparam int DEB_W = 20;
  localparam int LEN_W = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic PIN_IDLE = (ACT != 0) ? 1'b0 : 1'b1;

  logic clk = 1'b0, rst_n = 1'b0, pin = PIN_IDLE, edge_sel = 1'b0, clr = 1'b0;
  logic [DEB_W-1:0] deb = '0;
  logic [LEN_W-1:0] len = '0;
  logic lvl, trig, strch;
  logic [CNT_W-1:0] tcnt, dcnt;

  ext_trig_cond #(.ACT_LVL(ACT), .DEB_W(DEB_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .trig_ext_i(pin), .cfg_edge_i(edge_sel),
    .cfg_deb_i(deb), .cfg_len_i(len), .cnt_clr_i(clr), .lvl_o(lvl), .trig_o(trig),
    .trig_stretch_o(strch), .trig_cnt_o(tcnt), .drop_cnt_o(dcnt));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // model state
  logic h[3];              // pin values before the last three edges
  int   cyc, last_acc, dlat, llat, m_tc, m_dc;
  bit   has_acc;
  // per-scenario observation
  int   rel, trig_first, trig_last, trig_num, sh, run_len, max_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit act(input logic p);
    return (ACT != 0) ? p : ~p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) h[i] = PIN_IDLE;
    cyc = 0; last_acc = 0; dlat = 0; llat = 0; m_tc = 0; m_dc = 0; has_acc = 0;
  endtask

  task automatic obs_reset();
    rel = 0; trig_first = -1; trig_last = -1; trig_num = 0; sh = 0; run_len = 0; max_run = 0;
  endtask

  // One clock: advance the model with the inputs present before the edge,
  // then compare every output.
  task automatic step();
    bit a, b, q, acc, e_str;
    @(posedge clk); #1;
    a = act(h[1]);          // level seen two edges ago
    b = act(h[2]);          // one edge before that
    q = edge_sel ? (b && !a) : (!b && a);
    acc = q && (!has_acc || (cyc - last_acc) >= dlat + 1);
    if (acc) begin
      has_acc = 1; last_acc = cyc; dlat = int'(deb); llat = int'(len);
    end
    if (clr) begin
      m_tc = 0; m_dc = 0;
    end else begin
      if (acc)           m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
      if (q && !acc)     m_dc = (m_dc < CMAX) ? m_dc + 1 : CMAX;
    end
    e_str = has_acc && ((cyc - last_acc) < llat);
    h[2] = h[1]; h[1] = h[0]; h[0] = pin;
    cyc++;
    chk("trig_o", 32'(trig), 32'(acc));
    chk("trig_stretch_o", 32'(strch), 32'(e_str));
    chk("lvl_o", 32'(lvl), 32'(a));
    chk("trig_cnt_o", 32'(tcnt), 32'(m_tc));
    chk("drop_cnt_o", 32'(dcnt), 32'(m_dc));
    if (trig) begin
      if (trig_first < 0) trig_first = rel;
      trig_last = rel;
      trig_num++;
    end
    if (strch) begin sh++; run_len++; end else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    rel++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_pulse();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] hold_pat;
    model_reset();
    obs_reset();
    // reset values
    #2;
    chk("rst_trig", 32'(trig), 0);
    chk("rst_stretch", 32'(strch), 0);
    chk("rst_lvl", 32'(lvl), 0);
    chk("rst_tcnt", 32'(tcnt), 0);
    chk("rst_dcnt", 32'(dcnt), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // basic asserting edge
    edge_sel = 0; deb = 0; len = 4; pin = 1;
    run(4);
    obs_reset(); pin = 0;
    run(10);
    chk("basic_trig_at", 32'(trig_first), 2);
    chk("basic_trig_num", 32'(trig_num), 1);
    chk("basic_stretch_len", 32'(sh), 4);
    chk("basic_tcnt", 32'(tcnt), 1);
    chk("basic_lvl", 32'(lvl), 1);

    // edge select: deasserting edge only
    pin = 1; edge_sel = 1;
    run(5);
    clr_pulse();
    obs_reset(); pin = 0;
    run(5);
    chk("edgesel_no_fall", 32'(trig_num), 0);
    obs_reset(); pin = 1;
    run(6);
    chk("edgesel_rise_at", 32'(trig_first), 2);
    chk("edgesel_rise_num", 32'(trig_num), 1);

    // hold-off: qualifying edges at relative 0, 4, 8, 11
    edge_sel = 0; deb = 10; len = 0; pin = 1;
    run(15);
    clr_pulse();
    hold_pat = 16'b0000_0100_1100_1100; // bit i = pin at relative step i
    obs_reset();
    for (int i = 0; i < 16; i++) begin
      pin = hold_pat[i];
      step();
    end
    run(4);
    chk("hold_trig_num", 32'(trig_num), 2);
    chk("hold_first", 32'(trig_first), 2);
    chk("hold_last", 32'(trig_last), 13);
    chk("hold_drops", 32'(dcnt), 2);

    // retrigger extends stretch
    deb = 0; len = 20; pin = 1;
    run(15);
    obs_reset();
    pin = 0; run(3); pin = 1; run(5);
    pin = 0; run(3); pin = 1; run(40);
    chk("retrig_total", 32'(sh), 28);
    chk("retrig_contig", 32'(max_run), 28);

    // saturation then clear coincident with accept
    len = 2; obs_reset();
    for (int p = 0; p < 17; p++) begin
      pin = 0; run(2); pin = 1; run(2);
    end
    run(2);
    chk("sat_tcnt", 32'(tcnt), CMAX);
    chk("sat_pulses", 32'(trig_num), 17);
    pin = 0; step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_trig", 32'(trig), 1);
    chk("clr_tcnt", 32'(tcnt), 0);
    chk("clr_dcnt", 32'(dcnt), 0);
    step();
    chk("clr_after", 32'(tcnt), 0);

    // reset mid hold-off with stretch high
    deb = 10; len = 20; pin = 1;
    run(5);
    pin = 0; run(5);
    chk("pre_rst_stretch", 32'(strch), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_trig", 32'(trig), 0);
    chk("arst_stretch", 32'(strch), 0);
    chk("arst_lvl", 32'(lvl), 0);
    chk("arst_tcnt", 32'(tcnt), 0);
    chk("arst_dcnt", 32'(dcnt), 0);
    @(posedge clk); @(posedge clk); #1;
    edge_sel = 1; pin = 0;           // held active across release
    rst_n = 1'b1;
    model_reset();
    obs_reset();
    run(6);
    chk("post_rst_quiet", 32'(trig_num), 0);
    chk("post_rst_lvl", 32'(lvl), 1);
    obs_reset(); pin = 1;
    run(6);
    chk("post_rst_fresh", 32'(trig_first), 2);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) pin = ~pin;
      if ($urandom_range(0, 19) == 0) edge_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) deb = DEB_W'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) len = LEN_W'($urandom_range(0, 15));
      clr = ($urandom_range(0, 39) == 0);
      step();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
